// File: rtl/muldiv_hilo_if.sv
// Operand, HI/LO write and result bundle between execute-stage control and the multiply/divide unit.
interface muldiv_hilo_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wd;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wd,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wd,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into private HI/LO registers, 34-cycle start-to-done latency.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise op[0] is ignored and all ops are unsigned.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO writes accepted
// S_RUN  | 32 shift-add / restoring shift-subtract steps
// S_FIX  | sign correction and HI/LO writeback
module muldiv_hilo_unit #(
   parameter int CYCLES = 32
) (
   input logic          clk,
   input logic          reset,
   muldiv_hilo_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

   state_t      state, state_nx;
   logic        load, step, finish;
   logic [5:0]  count;
   logic [31:0] acc, lo_w, opnd, a_raw, hi_r, lo_r;
   logic        is_div, dz, done_r, dz_r;
   logic [31:0] a_abs, b_abs;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;
   logic [32:0] mul_sum, div_shift;
   logic [33:0] div_diff;

`ifdef MULDIV_SIGNED_EN
   logic sgn, neg_q, neg_r;

   assign sgn   = ~bus.op[0];
   assign a_abs = (sgn && bus.a[31]) ? -bus.a : bus.a;
   assign b_abs = (sgn && bus.b[31]) ? -bus.b : bus.b;

   // quotient/product sign from both operands, remainder sign from the dividend
   always_ff @(posedge clk) begin
      if (reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (load) begin
         neg_q <= sgn & (bus.a[31] ^ bus.b[31]);
         neg_r <= sgn & bus.a[31];
      end
   end

   assign prod_fix = neg_q ? -{acc, lo_w} : {acc, lo_w};
   assign quot_fix = neg_q ? -lo_w : lo_w;
   assign rem_fix  = neg_r ? -acc : acc;
`else
   logic unused_op0;

   assign unused_op0 = bus.op[0];
   assign a_abs      = bus.a;
   assign b_abs      = bus.b;
   assign prod_fix   = {acc, lo_w};
   assign quot_fix   = lo_w;
   assign rem_fix    = acc;
`endif

   assign mul_sum   = {1'b0, acc} + (lo_w[0] ? {1'b0, opnd} : 33'd0);
   assign div_shift = {acc, lo_w[31]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               load     = 1'b1;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            step = 1'b1;
            if (count == 6'(CYCLES - 1)) state_nx = S_FIX;
         end
         S_FIX: begin
            finish   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // acc:lo_w is partial product (multiply) or remainder:quotient (divide)
   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         acc    <= '0;
         lo_w   <= '0;
         opnd   <= '0;
         a_raw  <= '0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
      end else begin
         done_r <= finish;
         dz_r   <= finish & is_div & dz;
         if (load) begin
            a_raw  <= bus.a;
            is_div <= bus.op[1];
            dz     <= bus.op[1] && (bus.b == 32'd0);
            count  <= '0;
            acc    <= '0;
            if (bus.op[1]) begin
               lo_w <= a_abs;
               opnd <= b_abs;
            end else begin
               lo_w <= b_abs;
               opnd <= a_abs;
            end
         end
         if (step) begin
            count <= count + 6'd1;
            if (is_div) begin
               if (!div_diff[33]) begin
                  acc  <= div_diff[31:0];
                  lo_w <= {lo_w[30:0], 1'b1};
               end else begin
                  acc  <= div_shift[31:0];
                  lo_w <= {lo_w[30:0], 1'b0};
               end
            end else begin
               {acc, lo_w} <= {mul_sum, lo_w[31:1]};
            end
         end
         if (state == S_IDLE) begin
            if (bus.hi_we) hi_r <= bus.wd;
            if (bus.lo_we) lo_r <= bus.wd;
         end
         if (finish) begin
            if (!is_div) begin
               {hi_r, lo_r} <= prod_fix;
            end else if (dz) begin
               hi_r <= a_raw;
               lo_r <= '1;
            end else begin
               hi_r <= rem_fix;
               lo_r <= quot_fix;
            end
         end
      end
   end

   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = done_r;
   assign bus.div_by_zero = dz_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed and randomized checks of muldiv_hilo_unit against an arithmetic reference model.
module tb_muldiv_hilo_unit;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   muldiv_hilo_if bus ();

   muldiv_hilo_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;
   logic        exp_dz = 1'b0;
   logic [31:0] prev_hi;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      bit          sgn;
      longint      sa, sb, q, r;
      logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
      sgn = !op[0];
`else
      sgn = 1'b0;
`endif
      sa = $signed(a);
      sb = $signed(b);
      dz = 1'b0;
      if (!op[1]) begin
         if (sgn) p = sa * sb;
         else     p = {32'd0, a} * {32'd0, b};
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
         dz = 1'b1;
      end else if (sgn) begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end else begin
         hi = a % b;
         lo = a / b;
      end
   endfunction

   // drives start in cycle 0 and returns in cycle 1
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      model(op, a, b, exp_hi, exp_lo, exp_dz);
      tick();
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   // checks the remaining busy cycles, then the done cycle; returns in the done cycle
   task automatic finish_op(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
         tick();
      end
      chk({tag, " busy_window"}, 32'(bad), 32'd0);
      chk({tag, " done"}, 32'(bus.done), 32'd1);
      chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
      chk({tag, " hi"}, bus.hi, exp_hi);
      chk({tag, " lo"}, bus.lo, exp_lo);
      chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dz));
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb, rwd;
      int          bad;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wd    = '0;
      tick();
      tick();
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset dz", 32'(bus.div_by_zero), 32'd0);
      chk("reset hi", bus.hi, 32'd0);
      chk("reset lo", bus.lo, 32'd0);
      reset = 1'b0;
      tick();

      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish_op("multu_max", 33);
      chk("multu_max const_hi", exp_hi, 32'hFFFF_FFFE);
      chk("multu_max const_lo", exp_lo, 32'h0000_0001);
      launch(2'b00, 32'hFFFF_FFFD, 32'd5);
      finish_op("mult_neg3x5", 33);
      tick();
      chk("done_one_cycle", 32'(bus.done), 32'd0);

      launch(2'b10, 32'hFFFF_FFF9, 32'd2);
      finish_op("div_neg7by2", 33);
      tick();
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      finish_op("div_overflow", 33);
      tick();

      launch(2'b11, 32'd100, 32'd0);
      finish_op("divu_by_zero", 33);
      tick();
      chk("dz_clears", 32'(bus.div_by_zero), 32'd0);
      launch(2'b01, 32'd2, 32'd3);
      finish_op("multu_2x3", 33);
      tick();

      bus.wd    = 32'h5555_AAAA;
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      launch(2'b11, 32'd1000, 32'd33);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      chk("we_with_start hi", bus.hi, 32'h5555_AAAA);
      chk("we_with_start lo", bus.lo, 32'h5555_AAAA);
      finish_op("divu_after_we", 33);
      tick();

      prev_hi = exp_hi;
      launch(2'b01, 32'd7, 32'd9);
      for (int i = 0; i < 4; i++) tick();
      bus.start = 1'b1;
      bus.op    = 2'b11;
      bus.hi_we = 1'b1;
      bus.wd    = 32'h0000_1234;
      tick();
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      chk("busy_we_dropped hi", bus.hi, prev_hi);
      finish_op("multu_7x9", 28);
      tick();
      bus.lo_we = 1'b1;
      bus.wd    = 32'h0000_ABCD;
      tick();
      bus.lo_we = 1'b0;
      exp_lo    = 32'h0000_ABCD;
      chk("mtlo lo", bus.lo, exp_lo);
      chk("mtlo hi_kept", bus.hi, exp_hi);
      rwd       = $urandom;
      bus.wd    = rwd;
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      tick();
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      chk("mthi_mtlo hi", bus.hi, rwd);
      chk("mthi_mtlo lo", bus.lo, rwd);

      launch(2'b11, 32'd50, 32'd7);
      for (int i = 0; i < 9; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort hi", bus.hi, 32'd0);
      chk("abort lo", bus.lo, 32'd0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done !== 1'b0) bad++;
         tick();
      end
      chk("abort no_done", 32'(bad), 32'd0);
      launch(2'b11, 32'd50, 32'd7);
      finish_op("divu_50by7", 33);
      tick();

      for (int k = 0; k < 12; k++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
         launch(rop, ra, rb);
         finish_op($sformatf("rand%0d op%0d", k, rop), 33);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
Iterative multiply/divide unit that consumes the two register-file read operands (RD1, RD2) and implements MIPS MULT/MULTU/DIV/DIVU into private HI/LO registers. It sits directly downstream of the register file, beside the ALU in the execute stage. A start/busy/done handshake lets the control unit stall while the operation runs. HI/LO are read by MFHI/MFLO and written directly by MTHI/MTLO.

Parameters:
CYCLES, 32, number of iteration cycles; fixed at the operand width, must equal 32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  32  operand A: multiplicand or dividend (from RD1)
b  input  32  operand B: multiplier or divisor (from RD2)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wd  input  32  MTHI/MTLO write data
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
div_by_zero  output  1  valid with done; divisor was zero
hi  output  32  HI register (MFHI source)
lo  output  32  LO register (MFLO source)

Behaviour:
- One clock, synchronous active-high reset. On reset: state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0.
- States:
  - IDLE: if start=1, latch a, b and op, take absolute values for signed ops, record result signs, clear the accumulator, set count=0, go to RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; count increments; after 32 steps go to FIX.
  - FIX: apply sign correction, write hi/lo at the end of this cycle, go to IDLE with done=1.
- Timing: start high in cycle 0. busy=1 in cycles 1..33, with RUN in cycles 1..32 and FIX in cycle 33. In cycle 34: done=1, busy=0, and hi/lo hold the new result. done is high for exactly one cycle.
- start while busy=1 is ignored; there is no queuing.
- start in the done cycle is accepted, since the unit is in IDLE.
- Multiply: {hi,lo} = 64-bit product.
  - MULTU: unsigned × unsigned.
  - MULT: two's-complement × two's-complement.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- Divide by zero (b=0, DIV or DIVU): run the full latency; hi=a (raw), lo=0xFFFFFFFF; div_by_zero=1 for the done cycle only. It is 0 otherwise and for all multiplies.
- hi_we/lo_we:
  - In IDLE: the register takes wd at the next edge.
  - While busy=1: ignored and dropped.
  - Simultaneous with an accepted start: the write applies, and the later result overwrites it.
  - hi_we and lo_we may assert together.
- Reset mid-operation aborts: no hi/lo write, no done pulse, busy=0 in the following cycle.
- hi/lo are plain register outputs with no combinational path from a or b.

Optional Feature:
Macro: MULDIV_SIGNED_EN.
- Defined: MULT and DIV perform signed arithmetic as described above.
- Undefined: op[0] is ignored. MULT behaves as MULTU and DIV behaves as DIVU. No sign-correction logic is generated; the FIX state still exists and the latency is unchanged.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start in cycle 0 -> busy in cycles 1..33; done in cycle 34 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Without MULDIV_SIGNED_EN -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> done with div_by_zero=1, hi=0x00000064, lo=0xFFFFFFFF. A following MULTU 2×3 -> div_by_zero=0, hi=0, lo=6.
- Start MULTU 7×9, then in cycle 5 assert start with other operands and hi_we with wd=0x1234 -> both ignored; cycle 34 gives hi=0, lo=63. Then in IDLE assert lo_we with wd=0xABCD -> lo=0xABCD next cycle.
- Start DIVU 50/7; assert reset in cycle 10 -> busy=0 in cycle 11, hi=lo=0, no done pulse. A new start afterwards completes normally with lo=7, hi=1.
